// File: rtl/axi_sram_slave.sv
// AXI4 responder mapping INCR/FIXED/WRAP bursts onto a dual-port synchronous SRAM.
// Latency: W beat writes SRAM in its handshake cycle, B one cycle after last beat; R data 2 cycles after AR, 2 cycles/beat.
// Backpressure: BREADY low holds B and blocks AW; RREADY low holds R outputs stable and stalls further SRAM reads.
module axi_sram_slave #(
    parameter int          ID_WIDTH   = 4,
    parameter int          DATA_WIDTH = 32,
    parameter int          MEM_AW     = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                    BUS_CLK,
    input  logic                    BUS_RST,
    // write address
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [31:0]             AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    // write data
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    // write response
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    // read address
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [31:0]             ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    // read data
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY,
    // SRAM ports
    output logic                    mem_we,
    output logic [MEM_AW-1:0]       mem_waddr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_re,
    output logic [MEM_AW-1:0]       mem_raddr,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    // One spare MSB so an INCR burst running past the top of the 32-bit space never wraps back into range.
    localparam int IDX_W  = 33 - OFF;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DATA  = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_ISSUE = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;

    function automatic logic [IDX_W-1:0] start_idx(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> OFF);
    endfunction

    // Errors that apply to every beat of a burst regardless of its address.
    function automatic logic burst_bad(input logic [31:0] addr, input logic [7:0] len,
                                       input logic [1:0] burst);
        logic wrap_ok;
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_ok) || (addr < BASE_ADDR);
    endfunction

    function automatic logic idx_oob(input logic [IDX_W-1:0] idx);
        return idx >= (IDX_W'(1) << MEM_AW);
    endfunction

    // WRAP keeps the high bits and increments only inside the (LEN+1)-word aligned block.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input logic [7:0] len, input logic [1:0] burst);
        logic [IDX_W-1:0] mask;
        logic [IDX_W-1:0] inc;
        mask = IDX_W'(len);
        inc  = idx + IDX_W'(1);
        case (burst)
            BURST_INCR: return inc;
            BURST_WRAP: return (idx & ~mask) | (inc & mask);
            default:    return idx;
        endcase
    endfunction

    // ---------------- write channel ----------------
    logic [1:0]          w_state_q, w_state_d;
    logic [ID_WIDTH-1:0] w_id_q, w_id_d;
    logic [IDX_W-1:0]    w_idx_q, w_idx_d;
    logic [7:0]          w_len_q, w_len_d;
    logic [1:0]          w_burst_q, w_burst_d;
    logic                w_bad_q, w_bad_d;
    logic [7:0]          w_beat_q, w_beat_d;
    logic                w_err_q, w_err_d;
    logic                w_beat_err;
    logic                w_last_beat;

    assign w_beat_err  = w_bad_q || idx_oob(w_idx_q);
    assign w_last_beat = (w_beat_q == w_len_q);

    // Write FSM next state: accept AW, consume exactly LEN+1 beats, then hold B until taken.
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_bad_d   = w_bad_q;
        w_beat_d  = w_beat_q;
        w_err_d   = w_err_q;
        case (w_state_q)
            W_IDLE: begin
                if (AWVALID) begin
                    w_id_d    = AWID;
                    w_idx_d   = start_idx(AWADDR);
                    w_len_d   = AWLEN;
                    w_burst_d = AWBURST;
                    w_bad_d   = burst_bad(AWADDR, AWLEN, AWBURST);
                    w_beat_d  = 8'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID) begin
                    // A misplaced WLAST is reported but does not change the burst length.
                    if (w_beat_err || (WLAST != w_last_beat)) begin
                        w_err_d = 1'b1;
                    end
                    if (w_last_beat) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_beat_d = w_beat_q + 8'd1;
                        w_idx_d  = next_idx(w_idx_q, w_len_q, w_burst_q);
                    end
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write channel state registers; reset abandons any burst in flight without a response.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_burst_q <= '0;
            w_bad_q   <= 1'b0;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_bad_q   <= w_bad_d;
            w_beat_q  <= w_beat_d;
            w_err_q   <= w_err_d;
        end
    end

    assign AWREADY   = (w_state_q == W_IDLE) && !BUS_RST;
    assign WREADY    = (w_state_q == W_DATA);
    assign BVALID    = (w_state_q == W_RESP);
    assign BID       = BVALID ? w_id_q : '0;
    assign BRESP     = (BVALID && w_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign mem_we    = (w_state_q == W_DATA) && WVALID && !w_beat_err;
    assign mem_waddr = mem_we ? w_idx_q[MEM_AW-1:0] : '0;
    assign mem_wdata = mem_we ? WDATA : '0;
    assign mem_wstrb = mem_we ? WSTRB : '0;

    // ---------------- read channel ----------------
    logic [1:0]            r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [IDX_W-1:0]      r_idx_q, r_idx_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic                  r_bad_q, r_bad_d;
    logic [7:0]            r_beat_q, r_beat_d;
    logic                  r_fresh_q, r_fresh_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                  r_beat_err;
    logic [DATA_WIDTH-1:0] r_rdata_cur;

    assign r_beat_err = r_bad_q || idx_oob(r_idx_q);
    // SRAM output is only valid the cycle after the read; afterwards the captured copy holds RDATA steady.
    assign r_rdata_cur = r_fresh_q ? (r_beat_err ? '0 : mem_rdata) : r_data_q;

    // Read FSM next state: issue one SRAM read, present the beat, advance on handshake.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_bad_d   = r_bad_q;
        r_beat_d  = r_beat_q;
        r_fresh_d = r_fresh_q;
        r_data_d  = r_data_q;
        case (r_state_q)
            R_IDLE: begin
                if (ARVALID) begin
                    r_id_d    = ARID;
                    r_idx_d   = start_idx(ARADDR);
                    r_len_d   = ARLEN;
                    r_burst_d = ARBURST;
                    r_bad_d   = burst_bad(ARADDR, ARLEN, ARBURST);
                    r_beat_d  = 8'd0;
                    r_state_d = R_ISSUE;
                end
            end
            R_ISSUE: begin
                r_fresh_d = 1'b1;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                r_fresh_d = 1'b0;
                r_data_d  = r_rdata_cur;
                if (RREADY) begin
                    if (r_beat_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_beat_d  = r_beat_q + 8'd1;
                        r_idx_d   = next_idx(r_idx_q, r_len_q, r_burst_q);
                        r_state_d = R_ISSUE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read channel state registers; reset drops the burst and any beat being presented.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_burst_q <= '0;
            r_bad_q   <= 1'b0;
            r_beat_q  <= '0;
            r_fresh_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_bad_q   <= r_bad_d;
            r_beat_q  <= r_beat_d;
            r_fresh_q <= r_fresh_d;
            r_data_q  <= r_data_d;
        end
    end

    assign ARREADY   = (r_state_q == R_IDLE) && !BUS_RST;
    assign mem_re    = (r_state_q == R_ISSUE) && !r_beat_err;
    assign mem_raddr = mem_re ? r_idx_q[MEM_AW-1:0] : '0;
    assign RVALID    = (r_state_q == R_DATA);
    assign RDATA     = RVALID ? r_rdata_cur : '0;
    assign RID       = RVALID ? r_id_q : '0;
    assign RRESP     = (RVALID && r_beat_err) ? RESP_SLVERR : RESP_OKAY;
    assign RLAST     = RVALID && (r_beat_q == r_len_q);

endmodule

// File: tb/tb_axi_sram_slave.sv
// Testbench for axi_sram_slave: directed and random bursts against a transaction-level memory model.
// Latency: every wait on the DUT is bounded by a cycle budget.
// Backpressure: BREADY/RREADY stalls applied and output stability checked.
module tb_axi_sram_slave;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_re;
    logic [9:0]  mem_raddr;
    bit   [31:0] mem_rdata;

    axi_sram_slave #(.ID_WIDTH(4), .DATA_WIDTH(32), .MEM_AW(10), .BASE_ADDR(32'h0)) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    // SRAM attached to the DUT (read-before-write through non-blocking updates).
    bit [31:0] sram [1024];
    int        we_cnt;
    logic [9:0] last_waddr;
    always @(posedge BUS_CLK) begin
        if (mem_re) mem_rdata <= sram[mem_raddr];
        if (mem_we) begin
            for (int k = 0; k < 4; k++)
                if (mem_wstrb[k]) sram[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
            we_cnt     <= we_cnt + 1;
            last_waddr <= mem_waddr;
        end
    end

    // Reference model state.
    bit   [31:0] ref_mem [1024];
    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge BUS_CLK);
        #1;
    endtask

    // Word index of beat b, straight from the burst-type rules.
    function automatic int unsigned m_idx(input logic [31:0] addr, input int len,
                                          input logic [1:0] burst, input int b);
        int unsigned s, blk;
        s = addr >> 2;
        if (burst == 2'b01) return s + b;
        if (burst == 2'b10) begin
            blk = len + 1;
            return (s / blk) * blk + (s % blk + b) % blk;
        end
        return s;
    endfunction

    function automatic bit m_beat_err(input logic [31:0] addr, input int len,
                                      input logic [1:0] burst, input int b);
        if (burst == 2'b11) return 1'b1;
        if (burst == 2'b10 && !(len inside {1, 3, 7, 15})) return 1'b1;
        return m_idx(addr, len, burst, b) >= 1024;
    endfunction

    task automatic fill(input int len, input bit rnd_strb);
        for (int b = 0; b <= len; b++) begin
            wdat[b] = $urandom;
            wstb[b] = rnd_strb ? 4'($urandom) : 4'hF;
        end
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input int bad_last, input int bstall,
                             input string tag);
        int n, we0, exp_we;
        bit exp_err;
        logic [3:0] bid;
        logic [1:0] bresp;
        we0 = we_cnt;
        AWID = id; AWADDR = addr; AWLEN = 8'(len); AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin step(); n++; end
        chk({tag, "_awready"}, 128'(AWREADY), 128'(1));
        step();
        AWVALID = 1'b0;
        for (int b = 0; b <= len; b++) begin
            WVALID = 1'b0;
            repeat ($urandom_range(0, 1)) step();
            WDATA = wdat[b]; WSTRB = wstb[b]; WLAST = (b == len) || (b == bad_last); WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < 50) begin step(); n++; end
            chk({tag, "_wready"}, 128'(WREADY), 128'(1));
            step();
        end
        WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;
        n = 0;
        while (!BVALID && n < 50) begin step(); n++; end
        chk({tag, "_bvalid"}, 128'(BVALID), 128'(1));
        for (int i = 0; i < bstall; i++) begin
            step();
            chk({tag, "_bhold"}, 128'({BVALID, AWREADY}), 128'(2'b10));
        end
        bid = BID; bresp = BRESP;
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        exp_err = (bad_last >= 0) && (bad_last != len);
        exp_we  = 0;
        for (int b = 0; b <= len; b++) begin
            if (m_beat_err(addr, len, burst, b)) exp_err = 1'b1;
            else begin
                exp_we++;
                for (int k = 0; k < 4; k++)
                    if (wstb[b][k]) ref_mem[m_idx(addr, len, burst, b)][8*k +: 8] = wdat[b][8*k +: 8];
            end
        end
        chk({tag, "_bresp"}, 128'(bresp), 128'(exp_err ? 2'b10 : 2'b00));
        chk({tag, "_bid"}, 128'(bid), 128'(id));
        chk({tag, "_we_count"}, 128'(we_cnt - we0), 128'(exp_we));
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int stall_beat, input string tag);
        int n;
        bit err;
        logic [31:0] exp_d;
        logic [38:0] held;
        ARID = id; ARADDR = addr; ARLEN = 8'(len); ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin step(); n++; end
        chk({tag, "_arready"}, 128'(ARREADY), 128'(1));
        step();
        ARVALID = 1'b0;
        for (int b = 0; b <= len; b++) begin
            RREADY = 1'b0;
            repeat ($urandom_range(0, 1)) step();
            RREADY = 1'b1;
            n = 0;
            while (!RVALID && n < 50) begin step(); n++; end
            chk({tag, "_rvalid"}, 128'(RVALID), 128'(1));
            if (b == stall_beat) begin
                RREADY = 1'b0;
                held = {RID, RRESP, RLAST, RDATA};
                repeat (5) begin
                    step();
                    chk({tag, "_rhold"}, 128'({RVALID, RID, RRESP, RLAST, RDATA}), 128'({1'b1, held}));
                end
                RREADY = 1'b1;
            end
            err   = m_beat_err(addr, len, burst, b);
            exp_d = err ? 32'h0 : ref_mem[m_idx(addr, len, burst, b)];
            chk({tag, "_rdata"}, 128'(RDATA), 128'(exp_d));
            chk({tag, "_rresp"}, 128'(RRESP), 128'(err ? 2'b10 : 2'b00));
            chk({tag, "_rlast"}, 128'(RLAST), 128'(b == len));
            chk({tag, "_rid"}, 128'(RID), 128'(id));
            step();
        end
        RREADY = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wl [5] = '{1, 2, 3, 7, 15};
        int we0, len, stall;
        logic [1:0] bu;
        logic [31:0] addr;

        // Reset with busy inputs: every output must stay low.
        BUS_RST = 1'b1;
        AWID = 4'h3; AWADDR = 32'h40; AWLEN = 8'd0; AWBURST = 2'b01; AWVALID = 1'b1;
        WDATA = 32'hA5A5_5A5A; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        ARID = 4'h2; ARADDR = 32'h40; ARLEN = 8'd0; ARBURST = 2'b01; ARVALID = 1'b1; RREADY = 1'b1;
        repeat (3) step();
        chk("reset_outputs", 128'({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA,
                                  RRESP, RLAST, mem_we, mem_waddr, mem_wdata, mem_wstrb, mem_re,
                                  mem_raddr}), 128'(0));
        AWVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
        BUS_RST = 1'b0;
        step();
        chk("idle_ready", 128'({AWREADY, ARREADY, BVALID, RVALID}), 128'(4'b1100));

        // Single write then read-back.
        wdat[0] = 32'hDEAD_BEEF; wstb[0] = 4'hF;
        axi_write(4'h5, 32'h10, 0, 2'b01, -1, 0, "single_w");
        chk("single_w_waddr", 128'(last_waddr), 128'(4));
        axi_read(4'h6, 32'h10, 0, 2'b01, -1, "single_r");

        // INCR LEN=3 with a half-word strobe on beat 2.
        fill(3, 1'b0);
        wstb[2] = 4'b0011;
        axi_write(4'h1, 32'h0, 3, 2'b01, -1, 0, "incr_w");
        axi_read(4'h2, 32'h0, 3, 2'b01, -1, "incr_r");

        // Fill words 4..11 distinctly, then WRAP (6,7,4,5) and FIXED (9,9,9) reads.
        fill(7, 1'b0);
        axi_write(4'h7, 32'h10, 7, 2'b01, -1, 0, "fill_w");
        axi_read(4'h8, 32'h18, 3, 2'b10, -1, "wrap_r");
        axi_read(4'h9, 32'h24, 2, 2'b00, -1, "fixed_r");

        // Error cases.
        axi_read(4'hA, 32'h1000, 0, 2'b01, -1, "oob_r");
        fill(1, 1'b0);
        axi_write(4'hB, 32'h80, 1, 2'b11, -1, 0, "rsvd_w");
        fill(2, 1'b0);
        axi_write(4'hC, 32'h90, 2, 2'b10, -1, 0, "wrap2_w");
        axi_read(4'hC, 32'h90, 2, 2'b10, -1, "wrap2_r");
        fill(3, 1'b0);
        axi_write(4'hD, 32'hA0, 3, 2'b01, 1, 0, "early_wlast_w");
        axi_read(4'h3, 32'h0FF8, 3, 2'b01, -1, "cross_top_r");

        // Backpressure on R and B.
        axi_read(4'hE, 32'h0, 3, 2'b01, 1, "stall_r");
        fill(1, 1'b0);
        axi_write(4'hF, 32'h100, 1, 2'b01, -1, 4, "stall_w");

        // Concurrent AW/AR, then reset during beat 2 of a LEN=7 write.
        fill(7, 1'b0);
        we0 = we_cnt;
        AWID = 4'h4; AWADDR = 32'h200; AWLEN = 8'd7; AWBURST = 2'b01; AWVALID = 1'b1;
        ARID = 4'h5; ARADDR = 32'h300; ARLEN = 8'd7; ARBURST = 2'b01; ARVALID = 1'b1;
        chk("concurrent_ready", 128'({AWREADY, ARREADY}), 128'(2'b11));
        step();
        AWVALID = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
        for (int b = 0; b < 2; b++) begin
            WDATA = wdat[b]; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
            step();
            ref_mem[128 + b] = wdat[b];
        end
        chk("rst_mid_we_count", 128'(we_cnt - we0), 128'(2));
        WDATA = wdat[2];
        BUS_RST = 1'b1;
        #1;
        chk("rst_async_outputs", 128'({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA,
                                      RRESP, RLAST, mem_we, mem_waddr, mem_wdata, mem_wstrb, mem_re,
                                      mem_raddr}), 128'(0));
        step();
        chk("rst_edge_outputs", 128'({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA,
                                     RRESP, RLAST, mem_we, mem_waddr, mem_wdata, mem_wstrb, mem_re,
                                     mem_raddr}), 128'(0));
        WVALID = 1'b0;
        BUS_RST = 1'b0;
        step();
        chk("post_rst_we_count", 128'(we_cnt - we0), 128'(2));
        fill(0, 1'b0);
        axi_write(4'h6, 32'h40, 0, 2'b01, -1, 0, "post_rst_w");
        axi_read(4'h7, 32'h200, 3, 2'b01, -1, "post_rst_r");

        // Random bursts of every type, including illegal ones and ones running off the end.
        for (int t = 0; t < 40; t++) begin
            bu   = 2'($urandom_range(0, 3));
            len  = (bu == 2'b10) ? wl[$urandom_range(0, 4)] : int'($urandom_range(0, 7));
            addr = $urandom_range(0, 4300);
            if ($urandom_range(0, 1) == 1) begin
                fill(len, 1'b1);
                axi_write(4'($urandom), addr, len, bu, -1, int'($urandom_range(0, 2)), "rnd_w");
            end else begin
                stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
                axi_read(4'($urandom), addr, len, bu, stall, "rnd_r");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
